fir_param_adapt: RTL and testbench
==================================

// Module: fir_param_adapt
// PURPOSE
//   Parametrised N-tap FIR filter with coefficients reloadable at run time over the
//   sample input stream. AXI-Stream style slave/master handshakes with full back-pressure.
//   Pipelined datapath with rounding and saturation, plus a per-sample overflow flag.
//   Sits between the sample source and the downstream consumer. It is the generalised
//   successor of the fixed 3-tap adaptive-coefficient FIR.
// PARAMETERS
//   DATA_W   6  signed input sample width
//   COEF_W   6  signed coefficient width; COEF_W <= DATA_W
//   NTAPS    3  number of taps (>=2)
//   OUT_W    8  signed output width
//   SHIFT    0  right shift applied to the full-precision sum before rounding
// PORTS
//   clk                 in   1        single clock, rising edge
//   reset               in   1        asynchronous, active-low reset
//   s_axis_fir_tdata    in   DATA_W   sample or, while loading, coefficient (low COEF_W bits)
//   s_axis_fir_tvalid   in   1        input beat valid
//   s_axis_fir_tready   out  1        input beat accepted when valid&ready
//   s_set_coeffs        in   1        qualifies the current input beat as a coefficient beat
//   m_axis_fir_tdata    out  OUT_W    filtered sample, signed
//   m_axis_fir_tvalid   out  1        output beat valid
//   m_axis_fir_tready   in   1        downstream ready
//   m_axis_fir_tuser    out  1        1 = this output sample was saturated
// BEHAVIOUR
//   Reset (reset=0): delay line, pipeline and outputs are 0. m_tvalid=0. State RUN. Load counter 0.
//     coef[0]=1, coef[1..NTAPS-1]=0 (pass-through when SHIFT=0).
//   Stall: en = !m_tvalid | m_tready. All pipeline registers advance only when en=1.
//     m_tdata/m_tuser are held stable while m_tvalid=1 and m_tready=0.
//   Data path (RUN, s_set_coeffs=0): an accepted beat shifts into the delay line, x[0] newest.
//     Stage 1 registers p[k] = x[k]*coef[k]. Stage 2 registers the sum and round/saturate.
//     Latency: m_tvalid rises 3 clk edges after acceptance, without stalls. One sample/cycle throughput.
//   Arithmetic: the full-precision sum is DATA_W+COEF_W+clog2(NTAPS) bits.
//     r = (sum + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT.
//     Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. tuser=1 iff the clamp was applied.
//   s_tready = en & !(s_set_coeffs & pipe_busy). pipe_busy = any valid bit in stage1/stage2/output.
//     A coefficient load therefore waits for the pipeline to drain, so outputs never mix coefficient sets.
//   FSM RUN -> LOAD: on an accepted beat with s_set_coeffs=1.
//     shadow[0] = tdata[COEF_W-1:0], cnt=1.
//     When NTAPS==1 is excluded, LOAD is always entered.
//   In LOAD, each accepted beat with s_set_coeffs=1 sets shadow[cnt]=tdata and cnt++.
//     On beat cnt==NTAPS-1: coef <= shadow (all taps in one cycle), cnt=0, -> RUN.
//     New coefficients apply from the next accepted data sample.
//   Abort: an accepted beat in LOAD with s_set_coeffs=0 discards shadow. coef is unchanged, cnt=0, -> RUN.
//     That beat is processed as a normal data sample.
//   Coefficient beats never enter the delay line and never produce output. The delay-line contents are kept across a load.
//   s_set_coeffs with s_tvalid=0 has no effect.
//   Asynchronous reset mid-load or mid-stream returns everything to the reset values above; in-flight samples are dropped.
// STRUCTURE
//   Shared package fir_pkg: clog2 function, ACC_W derivation, sat/round function, FSM state encoding (RUN, LOAD).
//   Sub-module fir_round_sat: combinational round + clamp from ACC_W to OUT_W, outputs data and sat flag.
//   Top level holds the delay line, coef/shadow banks, FSM, the 3-stage valid pipeline and the handshake logic.
// TESTING (defaults; coefficient beats 7, -5, 27 = 6'b000111, 6'b111011, 6'b011011)
//   Reset then impulse x=1 followed by zeros, no load -> outputs 1,0,0,... tuser=0 (reset coefficients).
//   Load 7,-5,27 (3 beats with s_set_coeffs=1), then impulse 1 and zeros
//     -> outputs 7,-5,27,0,...; first valid 3 cycles after acceptance.
//   Same coefficients, constant input 31 -> steady-state 127 with tuser=1.
//     Constant -32 -> -128 with tuser=1. Input 1 steady -> 29 with tuser=0.
//   Hold m_tready=0 for 5 cycles mid-stream -> m_tdata stable, s_tready=0 once full.
//     No sample is lost or duplicated against the golden model.
//   Raise s_set_coeffs while samples are in flight -> s_tready=0 until the 3 outputs drain.
//     Load 2 beats then send a data beat -> old coefficients kept (abort), data beat filtered.
//   Assert reset mid-load after 2 beats -> m_tvalid=0, coef back to impulse. A fresh full load then succeeds.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FSM encoding and width helpers for the reloadable FIR
package fir_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } fsm_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Full-precision accumulator: one product plus growth for summing ntaps of them.
  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_param_adapt_if.sv
// rtl/fir_param_adapt_if.sv - sample/coefficient input stream and filtered output stream
interface fir_param_adapt_if #(
  parameter int DATA_W = 6,
  parameter int OUT_W  = 8
);
  logic signed [DATA_W-1:0] s_axis_fir_tdata;
  logic                     s_axis_fir_tvalid;
  logic                     s_axis_fir_tready;
  logic                     s_set_coeffs;
  logic signed [OUT_W-1:0]  m_axis_fir_tdata;
  logic                     m_axis_fir_tvalid;
  logic                     m_axis_fir_tready;
  logic                     m_axis_fir_tuser;

  modport master (
    output s_axis_fir_tdata, s_axis_fir_tvalid, s_set_coeffs, m_axis_fir_tready,
    input  s_axis_fir_tready, m_axis_fir_tdata, m_axis_fir_tvalid, m_axis_fir_tuser
  );

  modport slave (
    input  s_axis_fir_tdata, s_axis_fir_tvalid, s_set_coeffs, m_axis_fir_tready,
    output s_axis_fir_tready, m_axis_fir_tdata, m_axis_fir_tvalid, m_axis_fir_tuser
  );
endinterface

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up right shift and clamp of the accumulator to OUT_W
module fir_round_sat #(
  parameter int ACC_W = 14,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);
  // One extra bit so adding the rounding bias can never wrap.
  localparam int EXT_W  = ACC_W + 1;
  localparam int HALF_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
  localparam int MAX_I  = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [EXT_W-1:0] HALF = EXT_W'(HALF_I);
  localparam logic signed [EXT_W-1:0] MAXV = EXT_W'(MAX_I);
  localparam logic signed [EXT_W-1:0] MINV = EXT_W'(-MAX_I - 1);

  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    biased  = EXT_W'(sum) + HALF;
    shifted = biased >>> SHIFT;
    sat     = 1'b0;
    data    = shifted[OUT_W-1:0];
    if (shifted > MAXV) begin
      sat  = 1'b1;
      data = MAXV[OUT_W-1:0];
    end else if (shifted < MINV) begin
      sat  = 1'b1;
      data = MINV[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/fir_param_adapt.sv
// rtl/fir_param_adapt.sv - N-tap pipelined FIR with coefficients reloaded over the sample stream
module fir_param_adapt
  import fir_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int COEF_W = 6,
  parameter int NTAPS  = 3,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  fir_param_adapt_if.slave  bus
);
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = clog2(NTAPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NTAPS - 1);

  fsm_state_t               state, state_nx;
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic signed [DATA_W-1:0] x      [NTAPS];
  logic signed [DATA_W-1:0] xsh    [NTAPS];
  logic signed [COEF_W-1:0] coef   [NTAPS];
  logic signed [COEF_W-1:0] shadow [NTAPS];
  logic signed [PROD_W-1:0] p      [NTAPS];
  logic signed [PROD_W-1:0] p_c    [NTAPS];
  logic signed [COEF_W-1:0] coef_in;
  logic signed [ACC_W-1:0]  sum_c, sum_r;
  logic signed [OUT_W-1:0]  rs_data;
  logic                     rs_sat;
  logic                     vx, v1, v2;
  logic                     en, pipe_busy, acc, data_acc, coef_we, commit;

  // A coefficient beat waits until stage1/stage2/output are empty so no output mixes sets.
  assign en        = !bus.m_axis_fir_tvalid | bus.m_axis_fir_tready;
  assign pipe_busy = v1 | v2 | bus.m_axis_fir_tvalid;
  assign bus.s_axis_fir_tready = en & !(bus.s_set_coeffs & pipe_busy);
  assign acc       = bus.s_axis_fir_tvalid & bus.s_axis_fir_tready;
  assign coef_in   = bus.s_axis_fir_tdata[COEF_W-1:0];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    data_acc = 1'b0;
    coef_we  = 1'b0;
    commit   = 1'b0;
    if (acc) begin
      if (bus.s_set_coeffs) begin
        coef_we = 1'b1;
        if (state == RUN) begin
          cnt_nx   = CNT_W'(1);
          state_nx = LOAD;
        end else if (cnt == LAST) begin
          commit   = 1'b1;
          cnt_nx   = '0;
          state_nx = RUN;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end else begin
        data_acc = 1'b1;
        if (state == LOAD) begin
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The final beat is written straight into coef alongside the buffered ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        coef[k]   <= (k == 0) ? COEF_W'(1) : '0;
        shadow[k] <= '0;
      end
    end else if (coef_we) begin
      shadow[cnt] <= coef_in;
      if (commit) begin
        for (int k = 0; k < NTAPS; k++)
          coef[k] <= (CNT_W'(k) == cnt) ? coef_in : shadow[k];
      end
    end
  end

  always_comb begin
    xsh[0] = bus.s_axis_fir_tdata;
    for (int k = 1; k < NTAPS; k++) xsh[k] = x[k-1];
    sum_c = '0;
    for (int k = 0; k < NTAPS; k++) begin
      p_c[k] = PROD_W'(x[k]) * PROD_W'(coef[k]);
      sum_c  = sum_c + ACC_W'(p[k]);
    end
  end

  fir_round_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_round_sat (
    .sum  (sum_r),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        x[k] <= '0;
        p[k] <= '0;
      end
      vx    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      sum_r <= '0;
      bus.m_axis_fir_tvalid <= 1'b0;
      bus.m_axis_fir_tdata  <= '0;
      bus.m_axis_fir_tuser  <= 1'b0;
    end else begin
      if (data_acc) x <= xsh;
      if (en) begin
        vx    <= data_acc;
        v1    <= vx;
        p     <= p_c;
        v2    <= v1;
        sum_r <= sum_c;
        bus.m_axis_fir_tvalid <= v2;
        bus.m_axis_fir_tdata  <= rs_data;
        bus.m_axis_fir_tuser  <= rs_sat;
      end
    end
  end
endmodule

// File: tb/tb_fir_param_adapt.sv
// tb/tb_fir_param_adapt.sv - directed and random stimulus against a queue-based FIR reference
module tb_fir_param_adapt;
  localparam int DATA_W = 6;
  localparam int COEF_W = 6;
  localparam int NTAPS  = 3;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fir_param_adapt_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  fir_param_adapt #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int coef_m [NTAPS];
  int xs_m   [NTAPS];
  int shadow_m [$];
  bit loading;
  int exp_d [$];
  bit exp_u [$];
  bit obs_mvalid, obs_tready, last_acc;
  int last_d;
  bit last_u;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int sext(input int v, input int w);
    int r;
    r = v & ((1 << w) - 1);
    if (r >= (1 << (w - 1))) r = r - (1 << w);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      coef_m[k] = (k == 0) ? 1 : 0;
      xs_m[k] = 0;
    end
    shadow_m.delete();
    loading = 0;
    exp_d.delete();
    exp_u.delete();
  endtask

  // Reference: coefficient beats gather into a list committed once NTAPS arrive; data beats filter.
  task automatic model_accept(input int raw, input bit set);
    int sum, r, half, hi, lo;
    if (set) begin
      if (!loading) begin
        shadow_m.delete();
        loading = 1;
      end
      shadow_m.push_back(sext(raw, COEF_W));
      if (shadow_m.size() == NTAPS) begin
        for (int k = 0; k < NTAPS; k++) coef_m[k] = shadow_m[k];
        loading = 0;
      end
    end else begin
      loading = 0;
      for (int k = NTAPS - 1; k > 0; k--) xs_m[k] = xs_m[k-1];
      xs_m[0] = sext(raw, DATA_W);
      sum = 0;
      for (int k = 0; k < NTAPS; k++) sum += xs_m[k] * coef_m[k];
      half = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
      r = (sum + half) >>> SHIFT;
      hi = (1 << (OUT_W - 1)) - 1;
      lo = -(1 << (OUT_W - 1));
      if (r > hi) begin exp_d.push_back(hi); exp_u.push_back(1'b1); end
      else if (r < lo) begin exp_d.push_back(lo); exp_u.push_back(1'b1); end
      else begin exp_d.push_back(r); exp_u.push_back(1'b0); end
    end
  endtask

  // Called at a falling edge: sample, check, let the rising edge pass, update the model.
  task automatic cycle();
    int raw;
    bit set, fire;
    #1;
    obs_mvalid = bus.m_axis_fir_tvalid;
    obs_tready = bus.s_axis_fir_tready;
    last_acc = bus.s_axis_fir_tvalid && bus.s_axis_fir_tready;
    fire = bus.m_axis_fir_tvalid && bus.m_axis_fir_tready;
    raw = int'(bus.s_axis_fir_tdata);
    set = bus.s_set_coeffs;
    if (obs_mvalid) begin
      if (exp_d.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        chk("out_data", bus.m_axis_fir_tdata, exp_d[0]);
        chk("out_user", bus.m_axis_fir_tuser, exp_u[0]);
        if (fire) begin
          last_d = int'(bus.m_axis_fir_tdata);
          last_u = bus.m_axis_fir_tuser;
          void'(exp_d.pop_front());
          void'(exp_u.pop_front());
        end
      end
    end
    @(posedge clk);
    if (last_acc) model_accept(raw, set);
    @(negedge clk);
  endtask

  task automatic send(input int raw, input bit set);
    bus.s_axis_fir_tvalid = 1'b1;
    bus.s_axis_fir_tdata = DATA_W'(raw);
    bus.s_set_coeffs = set;
    for (int n = 0; n < 50; n++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 0, 1);
    bus.s_axis_fir_tvalid = 1'b0;
    bus.s_set_coeffs = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.s_axis_fir_tdata = '0;
    bus.s_axis_fir_tvalid = 1'b0;
    bus.s_set_coeffs = 1'b0;
    bus.m_axis_fir_tready = 1'b1;
    last_acc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mvalid", bus.m_axis_fir_tvalid, 0);
    chk("rst_mdata", bus.m_axis_fir_tdata, 0);
    chk("rst_muser", bus.m_axis_fir_tuser, 0);
    chk("rst_tready", bus.s_axis_fir_tready, 1);
    reset = 1'b1;
    @(negedge clk);

    // Reset coefficients pass the impulse straight through.
    send(1, 0);
    for (int i = 0; i < 4; i++) send(0, 0);
    idle(6);
    chk("impulse_last", last_d, 0);

    send(7, 1); send(-5, 1); send(27, 1);
    send(1, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("latency", obs_mvalid, (i == 3) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) send(0, 0);
    idle(6);

    for (int i = 0; i < 6; i++) send(31, 0);
    idle(6);
    chk("sat_pos_data", last_d, 127);
    chk("sat_pos_user", last_u, 1);
    for (int i = 0; i < 6; i++) send(-32, 0);
    idle(6);
    chk("sat_neg_data", last_d, -128);
    chk("sat_neg_user", last_u, 1);
    for (int i = 0; i < 6; i++) send(1, 0);
    idle(6);
    chk("steady_one_data", last_d, 29);
    chk("steady_one_user", last_u, 0);

    // Back-pressure: output held and input blocked while the consumer stalls.
    bus.s_axis_fir_tvalid = 1'b1;
    bus.s_axis_fir_tdata = DATA_W'($urandom);
    for (int i = 0; i < 14; i++) begin
      bus.m_axis_fir_tready = !(i >= 3 && i < 8);
      cycle();
      if (i == 7) chk("stall_tready", obs_tready, 0);
      if (last_acc) bus.s_axis_fir_tdata = DATA_W'($urandom);
    end
    bus.s_axis_fir_tvalid = 1'b0;
    bus.m_axis_fir_tready = 1'b1;
    idle(6);

    // Coefficient beat behind in-flight samples, then an aborted load.
    for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 63)), 0);
    bus.s_axis_fir_tvalid = 1'b1;
    bus.s_set_coeffs = 1'b1;
    bus.s_axis_fir_tdata = DATA_W'(5);
    cycle();
    chk("busy_block", obs_tready, 0);
    for (int n = 0; n < 20 && !last_acc; n++) cycle();
    chk("busy_drained", exp_d.size(), 0);
    chk("busy_accepted", last_acc, 1);
    send(-3, 1);
    send(int'($urandom_range(0, 63)), 0);
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 63)), 0);
    idle(6);

    // Asynchronous reset part-way through a load.
    send(3, 1); send(4, 1);
    reset = 1'b0;
    #2;
    chk("midload_rst_mvalid", bus.m_axis_fir_tvalid, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(1, 0);
    for (int i = 0; i < 3; i++) send(0, 0);
    idle(6);
    for (int k = 0; k < NTAPS; k++) send(int'($urandom_range(0, 63)), 1);
    for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 63)), 0);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      if (!bus.s_axis_fir_tvalid || last_acc) begin
        bus.s_axis_fir_tvalid = ($urandom_range(0, 3) != 0);
        bus.s_set_coeffs = loading ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 9) == 0);
        bus.s_axis_fir_tdata = DATA_W'($urandom);
      end
      bus.m_axis_fir_tready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.s_axis_fir_tvalid = 1'b0;
    bus.s_set_coeffs = 1'b0;
    bus.m_axis_fir_tready = 1'b1;
    for (int n = 0; n < 30 && (exp_d.size() != 0 || obs_mvalid); n++) cycle();
    chk("final_drain", exp_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
